ring_freq_meter: RTL and testbench

Gated frequency counter that sits directly downstream of the tapped ring oscillator. It consumes the free-running ring output `osc`, which is asynchronous to `clk`, and prescales it in the `osc` domain. It then synchronises the prescaled signal into the `clk` domain and counts its rising edges over a programmable gate window of `clk` cycles. The result is a registered, software-readable count that is proportional to ring frequency.

---
 rtl/ring_meas_pkg.sv | 35 +++
 rtl/osc_edge_sync.sv | 55 +++++
 rtl/ring_freq_meter.sv | 136 +++++++++++++
 tb/tb_ring_freq_meter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ring_meas_pkg.sv
// ---------------------------------------------------------------------------
// ring_meas_pkg
// Shared types, default parameter values and helpers for the ring oscillator
// frequency meter (ring_freq_meter and its osc_edge_sync front end).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package ring_meas_pkg;

    // Measurement sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } meas_state_t;

    localparam int DEF_CNT_W         = 16;
    localparam int DEF_PRESCALE_LOG2 = 4;
    localparam int DEF_GATE_MIN_LOG2 = 8;

    // gate_sel is 3 bits, so the longest gate is 2^(GATE_MIN_LOG2+7) cycles.
    // The gate counter must hold that length minus one.
    localparam int GATE_SEL_MAX = 7;

    function automatic int gate_cnt_w(input int min_log2);
        return min_log2 + GATE_SEL_MAX;
    endfunction

    localparam int GATE_CNT_W = gate_cnt_w(DEF_GATE_MIN_LOG2);

    // Gate length in clk cycles for a given selector.
    function automatic logic [31:0] gate_len(input logic [2:0] sel, input int min_log2);
        return 32'd1 << (min_log2 + int'(sel));
    endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// ---------------------------------------------------------------------------
// osc_edge_sync
// The only cross-domain logic of the meter. Prescales the ring oscillator in
// its own domain, brings the prescaled MSB into the clk domain through a
// two-flop synchroniser and flags its rising edges.
//   clk         in   system clock
//   rst         in   async active-high reset (clears both domains)
//   osc         in   ring oscillator output, asynchronous to clk
//   edge_pulse  out  one clk cycle high per synchronised rising edge of div
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module osc_edge_sync #(
    parameter int PRESCALE_LOG2 = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic osc,
    output logic edge_pulse
);

    logic [PRESCALE_LOG2-1:0] presc_r;
    logic                     div_s;
    logic                     meta_r;
    logic                     s_r;
    logic                     s_d_r;

    // Free-running prescaler in the osc domain.
    always_ff @(posedge osc or posedge rst) begin
        if (rst) begin
            presc_r <= {PRESCALE_LOG2{1'b0}};
        end else begin
            presc_r <= presc_r + {{(PRESCALE_LOG2-1){1'b0}}, 1'b1};
        end
    end

    // MSB toggles once per 2^(PRESCALE_LOG2-1) osc cycles, so it has one
    // rising edge per 2^PRESCALE_LOG2 osc cycles.
    assign div_s = presc_r[PRESCALE_LOG2-1];

    // Two-flop synchroniser followed by a delay flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            s_r    <= 1'b0;
            s_d_r  <= 1'b0;
        end else begin
            meta_r <= div_s;
            s_r    <= meta_r;
            s_d_r  <= s_r;
        end
    end

    assign edge_pulse = s_r & ~s_d_r;

endmodule

// File: rtl/ring_freq_meter.sv
// ---------------------------------------------------------------------------
// ring_freq_meter
// Gated frequency counter for the tapped ring oscillator. Counts synchronised
// prescaled osc edges over a window of 2^(GATE_MIN_LOG2+gate_sel) clk cycles
// and publishes a saturating count.
//   clk       in   system clock
//   rst       in   async active-high reset
//   osc       in   ring oscillator output (asynchronous)
//   start     in   request a measurement (sampled in IDLE only)
//   gate_sel  in   gate length selector, latched on an accepted start
//   busy      out  measurement in progress
//   done      out  one-cycle pulse, count/overflow valid and freshly updated
//   count     out  prescaled edge count of the last completed measurement
//   overflow  out  last measurement saturated count
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module ring_freq_meter
    import ring_meas_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int PRESCALE_LOG2 = DEF_PRESCALE_LOG2,
    parameter int GATE_MIN_LOG2 = DEF_GATE_MIN_LOG2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             osc,
    input  logic             start,
    input  logic [2:0]       gate_sel,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int GW = gate_cnt_w(GATE_MIN_LOG2);

    meas_state_t      state_r;
    logic [GW-1:0]    gate_cnt_r;
    logic [GW-1:0]    gate_load_s;
    logic [CNT_W-1:0] acc_r;
    logic             sat_r;
    logic [CNT_W-1:0] acc_next_s;
    logic             sat_next_s;
    logic             edge_s;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;

    osc_edge_sync #(
        .PRESCALE_LOG2 (PRESCALE_LOG2)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .osc        (osc),
        .edge_pulse (edge_s)
    );

    // Loading length-1 makes the counter read zero in the last gate cycle.
    assign gate_load_s = GW'(gate_len(gate_sel, GATE_MIN_LOG2) - 32'd1);

    // Saturating accumulator update for the current cycle's edge.
    always_comb begin
        acc_next_s = acc_r;
        sat_next_s = sat_r;
        if (edge_s) begin
            if (&acc_r) begin
                sat_next_s = 1'b1;
            end else begin
                acc_next_s = acc_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            acc_next_s = acc_r;
            sat_next_s = sat_r;
        end
    end

    // Measurement sequencer with registered outputs. The result is published
    // on the MEASURE->DONE transition (using the next-state accumulator so an
    // edge in the final gate cycle counts), so done and the new count appear
    // in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            gate_cnt_r <= {GW{1'b0}};
            acc_r      <= {CNT_W{1'b0}};
            sat_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        gate_cnt_r <= gate_load_s;
                        acc_r      <= {CNT_W{1'b0}};
                        sat_r      <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= MEASURE;
                    end
                end
                MEASURE: begin
                    acc_r <= acc_next_s;
                    sat_r <= sat_next_s;
                    if (gate_cnt_r == {GW{1'b0}}) begin
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        count_r    <= acc_next_s;
                        overflow_r <= sat_next_s;
                        state_r    <= DONE;
                    end else begin
                        gate_cnt_r <= gate_cnt_r - {{(GW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign count    = count_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_ring_freq_meter.sv
`timescale 1ns/1ps
module tb_ring_freq_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        osc = 1'b0;
    logic        start = 1'b0;
    logic        start_sat = 1'b0;
    logic [2:0]  gate_sel = 3'd0;

    logic        busy, done, overflow;
    logic [15:0] count;
    logic        busy_q, done_q, overflow_q;
    logic [3:0]  count_q;

    real osc_half = 1.5;
    bit  osc_en   = 1'b1;

    int nvec = 0;
    int nerr = 0;

    localparam int LIMIT = 40000;

    typedef struct {
        string      name;
        bit         use_sat;
        logic [2:0] sel;
        real        half;
        bit         osc_on;
        int         exp_busy;
        int         cnt_lo;
        int         cnt_hi;
        int         exp_ovf;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    always begin
        if (osc_en) #(osc_half) osc = ~osc;
        else #1;
    end

    ring_freq_meter dut (
        .clk      (clk),
        .rst      (rst),
        .osc      (osc),
        .start    (start),
        .gate_sel (gate_sel),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .overflow (overflow)
    );

    ring_freq_meter #(.CNT_W(4)) dut_sat (
        .clk      (clk),
        .rst      (rst),
        .osc      (osc),
        .start    (start_sat),
        .gate_sel (gate_sel),
        .busy     (busy_q),
        .done     (done_q),
        .count    (count_q),
        .overflow (overflow_q)
    );

    task automatic check(input string name, input longint act, input longint lo, input longint hi);
        nvec++;
        if (act < lo || act > hi) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic obs_busy(input bit s);
        return s ? busy_q : busy;
    endfunction

    function automatic logic obs_done(input bit s);
        return s ? done_q : done;
    endfunction

    // Wait (bounded) for done, counting busy cycles; returns at the done negedge.
    task automatic wait_done(input bit s, output int busy_cnt, output bit timed_out);
        int cyc;
        busy_cnt = 0;
        cyc = 0;
        while (!obs_done(s) && cyc < LIMIT) begin
            if (obs_busy(s)) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        timed_out = (cyc >= LIMIT);
    endtask

    task automatic pulse_start(input bit s, input logic [2:0] sel);
        @(negedge clk);
        gate_sel = sel;
        if (s) start_sat = 1'b1;
        else start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_sat = 1'b0;
    endtask

    task automatic quiet(input string name, input int n);
        int d_cnt;
        int b_cnt;
        d_cnt = 0;
        b_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) d_cnt++;
            if (busy) b_cnt++;
        end
        check({name, "_no_done"}, d_cnt, 0, 0);
        check({name, "_no_busy"}, b_cnt, 0, 0);
    endtask

    initial begin
        int  bc;
        bit  to;
        int  d_cnt;
        int  cyc;

        vecs[0] = '{"static_osc", 1'b0, 3'd1, 1.5, 1'b0,  512,   0,   0, 0};
        vecs[1] = '{"saturate",   1'b1, 3'd0, 1.5, 1'b1,  256,  15,  15, 1};
        vecs[2] = '{"long_gate",  1'b0, 3'd3, 3.5, 1'b1, 2048, 182, 183, 0};
        vecs[3] = '{"basic",      1'b0, 3'd0, 1.5, 1'b1,  256,  53,  54, 0};

        // Reset with osc running.
        repeat (5) @(negedge clk);
        check("rst_busy", busy, 0, 0);
        check("rst_done", done, 0, 0);
        check("rst_count", count, 0, 0);
        check("rst_overflow", overflow, 0, 0);
        rst = 1'b0;
        quiet("idle1000", 1000);

        // Table-driven measurements.
        foreach (vecs[k]) begin
            osc_half = vecs[k].half;
            osc_en   = vecs[k].osc_on;
            if (!vecs[k].osc_on) osc = 1'b0;
            repeat (20) @(negedge clk);
            pulse_start(vecs[k].use_sat, vecs[k].sel);
            wait_done(vecs[k].use_sat, bc, to);
            check({vecs[k].name, "_timeout"}, to, 0, 0);
            check({vecs[k].name, "_busy_cycles"}, bc, vecs[k].exp_busy, vecs[k].exp_busy);
            if (vecs[k].use_sat) begin
                check({vecs[k].name, "_count"}, count_q, vecs[k].cnt_lo, vecs[k].cnt_hi);
                check({vecs[k].name, "_overflow"}, overflow_q, vecs[k].exp_ovf, vecs[k].exp_ovf);
            end else begin
                check({vecs[k].name, "_count"}, count, vecs[k].cnt_lo, vecs[k].cnt_hi);
                check({vecs[k].name, "_overflow"}, overflow, vecs[k].exp_ovf, vecs[k].exp_ovf);
            end
            @(negedge clk);
            check({vecs[k].name, "_done_width"}, obs_done(vecs[k].use_sat), 0, 0);
        end
        osc_half = 1.5;
        osc_en   = 1'b1;

        // Count holds while idle.
        repeat (50) @(negedge clk);
        check("hold_count", count, 53, 54);

        // start pulsed mid-MEASURE is ignored.
        pulse_start(1'b0, 3'd0);
        bc = 0;
        cyc = 0;
        d_cnt = 0;
        while (!done && cyc < LIMIT) begin
            if (busy) bc++;
            start = (cyc == 50);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("midstart_timeout", cyc >= LIMIT, 0, 0);
        check("midstart_busy_cycles", bc, 256, 256);
        quiet("midstart_after", 400);

        // rst at cycle 100 of MEASURE aborts.
        pulse_start(1'b0, 3'd0);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0, 0);
        check("abort_count", count, 0, 0);
        check("abort_overflow", overflow, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        quiet("abort_after", 300);

        // start held high: back-to-back with one IDLE cycle between.
        @(negedge clk);
        gate_sel = 3'd0;
        start = 1'b1;
        wait_done(1'b0, bc, to);
        check("held_first_timeout", to, 0, 0);
        @(negedge clk);
        check("held_idle_gap", busy, 0, 0);
        @(negedge clk);
        check("held_restart", busy, 1, 1);
        wait_done(1'b0, bc, to);
        start = 1'b0;
        check("held_second_timeout", to, 0, 0);
        check("held_second_busy", bc, 256, 256);
        check("held_second_count", count, 53, 54);
        quiet("held_after", 300);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
